// File: rtl/sys_cfg_pkg.sv
// Shared configuration package for the AXI4-Lite to register-file bridge.
// Provides the bridge FSM state encoding and the AXI response codes.
package sys_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD,
    RD_WAIT,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axil_bram_bridge.sv
// axil_bram_bridge
// Bridges a single AXI4-Lite slave port onto a synchronous register file
// (BRAM-style: read data appears one cycle after the enable strobe).
// One transaction is in flight at a time; writes need AW and W together.
//
// Ports
//   clk, rst                     single clock, synchronous active-high reset
//   s_aw*/s_w*/s_b*              AXI4-Lite write address, data, response
//   s_ar*/s_r*                   AXI4-Lite read address, data
//   bram_en/we/addr/din          register file access (word-aligned address)
//   bram_dout                    register file read data (1-cycle latency)
//
// Build option
//   AXIL_BRAM_STRB_CHECK_EN  when defined, partial-strobe writes are refused:
//                            no register file access, SLVERR response.
module axil_bram_bridge
  import sys_cfg_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BYTE_NUM   = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [BYTE_NUM-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  bram_en,
  output logic [BYTE_NUM-1:0]   bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_din,
  input  logic [DATA_WIDTH-1:0] bram_dout
);

  // Clears the byte-offset bits so the register file always sees word addresses.
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(BYTE_NUM - 1);

  state_t                r_state;
  logic                  r_last_wr;  // 1 when the most recent grant was a write
  logic                  r_bvalid;
  logic [1:0]            r_bresp;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_bram_en;
  logic [BYTE_NUM-1:0]   r_bram_we;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_bram_din;

  logic w_idle;
  logic w_wr_grant;
  logic w_rd_grant;
  logic w_strb_ok;

`ifdef AXIL_BRAM_STRB_CHECK_EN
  assign w_strb_ok = &s_wstrb;
`else
  assign w_strb_ok = 1'b1;
`endif

  // Grants are combinational from IDLE. On contention the type that did not
  // win last time goes first; r_last_wr resets to 0 so writes win first.
  assign w_idle     = (r_state == IDLE);
  assign w_wr_grant = w_idle & s_awvalid & s_wvalid & (~s_arvalid | ~r_last_wr);
  assign w_rd_grant = w_idle & s_arvalid & ~w_wr_grant;

  assign s_awready = w_wr_grant;
  assign s_wready  = w_wr_grant;
  assign s_arready = w_rd_grant;
  assign s_bvalid  = r_bvalid;
  assign s_bresp   = r_bresp;
  assign s_rvalid  = r_rvalid;
  assign s_rdata   = r_rdata;
  assign s_rresp   = RESP_OKAY;
  assign bram_en   = r_bram_en;
  assign bram_we   = r_bram_we;
  assign bram_addr = r_bram_addr;
  assign bram_din  = r_bram_din;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_last_wr   <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_bram_en   <= 1'b0;
      r_bram_we   <= '0;
      r_bram_addr <= '0;
      r_bram_din  <= '0;
    end else begin
      // Enable and write strobes are single-cycle pulses in WR/RD only.
      r_bram_en <= 1'b0;
      r_bram_we <= '0;
      case (r_state)
        IDLE: begin
          if (w_wr_grant) begin
            r_state     <= WR;
            r_last_wr   <= 1'b1;
            r_bram_en   <= w_strb_ok;
            r_bram_we   <= w_strb_ok ? s_wstrb : '0;
            r_bram_addr <= s_awaddr & ADDR_MASK;
            r_bram_din  <= s_wdata;
            r_bresp     <= w_strb_ok ? RESP_OKAY : RESP_SLVERR;
          end else if (w_rd_grant) begin
            r_state     <= RD;
            r_last_wr   <= 1'b0;
            r_bram_en   <= 1'b1;
            r_bram_addr <= s_araddr & ADDR_MASK;
          end
        end
        WR: begin
          r_state  <= WR_RESP;
          r_bvalid <= 1'b1;
        end
        WR_RESP: begin
          if (s_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        RD: begin
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          // Register file output is valid now, one cycle after the enable.
          r_rdata  <= bram_dout;
          r_rvalid <= 1'b1;
          r_state  <= RD_RESP;
        end
        RD_RESP: begin
          if (s_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_bram_bridge.sv
// Testbench for axil_bram_bridge: randomized AXI4-Lite traffic against a
// transaction-level reference model (word memory + alternating arbiter),
// with a scoreboard monitor checking register-file accesses and responses.
module tb_axil_bram_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_awaddr = '0;
  logic        s_awvalid = 1'b0;
  logic        s_awready;
  logic [31:0] s_wdata = '0;
  logic [3:0]  s_wstrb = '0;
  logic        s_wvalid = 1'b0;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready = 1'b0;
  logic [31:0] s_araddr = '0;
  logic        s_arvalid = 1'b0;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready = 1'b0;
  logic        bram_en;
  logic [3:0]  bram_we;
  logic [31:0] bram_addr;
  logic [31:0] bram_din;
  logic [31:0] bram_dout = '0;

  always #5 clk = ~clk;

  axil_bram_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTE_NUM(4)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_din(bram_din), .bram_dout(bram_dout)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string nm, input string msg);
    nvec++;
    nerr++;
    $display("FAIL %s: %s (cycle %0d)", nm, msg, cyc);
  endtask

  // Bench register file: 16 words at 0x10000, read data one cycle after enable.
  logic [31:0] bmem[16];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_dout <= bmem[bram_addr[5:2]];
      for (int i = 0; i < 4; i++)
        if (bram_we[i]) bmem[bram_addr[5:2]][8*i +: 8] = bram_din[8*i +: 8];
    end
  end

  typedef struct {
    bit          is_wr;
    int          hs;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] din;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } exp_t;

  exp_t rsp_q[$];
  exp_t bram_q[$];

  // Reference model state
  logic [31:0] ref_mem[16];
  bit          m_last_wr = 1'b0;
  int          m_out = 0;
  int          m_free_cyc = 0;
  bit          glog[$];

  // Stimulus state
  bit          wpend = 1'b0, rpend = 1'b0;
  logic [31:0] w_addr = '0, w_data = '0, r_addr = '0;
  logic [3:0]  w_strb = '0;
  int          p_vld = 100, p_bready = 100, p_rready = 100;
  bit          hold5 = 1'b0;
  int          bv_cnt = 0;
  bit          b_seen = 1'b0, r_seen = 1'b0;

  // Monitor: consumes expectations whenever the DUT presents an output.
  exp_t me;
  always @(negedge clk) begin
    if (!rst) begin
      if (bram_q.size() > 0 && cyc > bram_q[0].hs + 1) begin
        fail_now("bram_missing", "expected register file access did not occur");
        void'(bram_q.pop_front());
      end
      if (bram_en) begin
        if (bram_q.size() == 0) fail_now("bram_unexpected", "bram_en with no access pending");
        else begin
          me = bram_q.pop_front();
          chk("bram_latency", cyc, me.hs + 1);
          chk("bram_addr", bram_addr, me.addr);
          chk("bram_we", {28'd0, bram_we}, {28'd0, me.we});
          if (me.is_wr) chk("bram_din", bram_din, me.din);
        end
      end else begin
        chk("bram_we_idle", {28'd0, bram_we}, 32'd0);
      end
      if (s_bvalid) begin
        if (rsp_q.size() == 0 || !rsp_q[0].is_wr) fail_now("b_unexpected", "bvalid with no write pending");
        else begin
          if (!b_seen) begin
            chk("b_latency", cyc, rsp_q[0].hs + 2);
            b_seen = 1'b1;
          end
          chk("bresp", {30'd0, s_bresp}, {30'd0, rsp_q[0].resp});
          if (s_bready) begin
            void'(rsp_q.pop_front());
            b_seen = 1'b0; m_out = 0; m_free_cyc = cyc + 1;
          end
        end
      end
      if (s_rvalid) begin
        if (rsp_q.size() == 0 || rsp_q[0].is_wr) fail_now("r_unexpected", "rvalid with no read pending");
        else begin
          if (!r_seen) begin
            chk("r_latency", cyc, rsp_q[0].hs + 3);
            r_seen = 1'b1;
          end
          chk("rdata", s_rdata, rsp_q[0].rdata);
          chk("rresp", {30'd0, s_rresp}, 32'd0);
          if (s_rready) begin
            void'(rsp_q.pop_front());
            r_seen = 1'b0; m_out = 0; m_free_cyc = cyc + 1;
          end
        end
      end
      if (rsp_q.size() > 0 && !b_seen && !r_seen &&
          cyc > rsp_q[0].hs + (rsp_q[0].is_wr ? 2 : 3)) begin
        fail_now("rsp_missing", "response valid did not rise in time");
        void'(rsp_q.pop_front());
        m_out = 0; m_free_cyc = cyc + 1;
      end
    end
  end

  task automatic new_write(input logic [3:0] st);
    w_addr = 32'h10000 | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
    w_data = $urandom;
    w_strb = st;
    wpend  = 1'b1;
  endtask

  task automatic new_read();
    r_addr = 32'h10000 | (32'($urandom_range(15)) << 2) | 32'($urandom_range(3));
    rpend  = 1'b1;
  endtask

  // One clock of stimulus plus the reference model's view of the handshakes.
  task automatic step();
    bit   free, ew, er, aw, ar, ok;
    exp_t e;
    @(posedge clk);
    #1;
    s_awvalid = wpend && ($urandom_range(99) < p_vld);
    s_wvalid  = wpend && ($urandom_range(99) < p_vld);
    s_awaddr  = w_addr;
    s_wdata   = w_data;
    s_wstrb   = w_strb;
    s_arvalid = rpend && ($urandom_range(99) < p_vld);
    s_araddr  = r_addr;
    s_bready  = hold5 ? (bv_cnt >= 5) : ($urandom_range(99) < p_bready);
    s_rready  = $urandom_range(99) < p_rready;
    @(negedge clk);
    free = (m_out == 0) && (cyc >= m_free_cyc);
    ew = free && s_awvalid && s_wvalid && (!s_arvalid || !m_last_wr);
    er = free && s_arvalid && !ew;
    aw = s_awvalid && s_awready && s_wvalid && s_wready;
    ar = s_arvalid && s_arready;
    chk("aw_w_ready_pair", {31'd0, s_awready}, {31'd0, s_wready});
    if (wpend || rpend) begin
      chk("wr_grant", {31'd0, aw}, {31'd0, ew});
      chk("rd_grant", {31'd0, ar}, {31'd0, er});
    end
    if (!free) chk("ready_busy", {29'd0, s_awready, s_wready, s_arready}, 32'd0);
    bv_cnt = s_bvalid ? bv_cnt + 1 : 0;
    if (aw) begin
`ifdef AXIL_BRAM_STRB_CHECK_EN
      ok = (w_strb == 4'hF);
`else
      ok = 1'b1;
`endif
      e.is_wr = 1'b1; e.hs = cyc; e.addr = {w_addr[31:2], 2'b00};
      e.we = w_strb; e.din = w_data; e.rdata = '0;
      e.resp = ok ? 2'b00 : 2'b10;
      if (ok) begin
        for (int i = 0; i < 4; i++)
          if (w_strb[i]) ref_mem[w_addr[5:2]][8*i +: 8] = w_data[8*i +: 8];
        bram_q.push_back(e);
      end
      rsp_q.push_back(e);
      m_out = 1; m_last_wr = 1'b1; glog.push_back(1'b1); wpend = 1'b0;
    end else if (ar) begin
      e.is_wr = 1'b0; e.hs = cyc; e.addr = {r_addr[31:2], 2'b00};
      e.we = 4'h0; e.din = '0; e.resp = 2'b00; e.rdata = ref_mem[r_addr[5:2]];
      bram_q.push_back(e);
      rsp_q.push_back(e);
      m_out = 1; m_last_wr = 1'b0; glog.push_back(1'b0); rpend = 1'b0;
    end
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((wpend || rpend || rsp_q.size() > 0 || bram_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    if (wpend || rpend || rsp_q.size() > 0 || bram_q.size() > 0)
      fail_now("timeout", "transactions still outstanding after cycle budget");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b0; s_rready = 1'b0;
    wpend = 1'b0; rpend = 1'b0;
    rsp_q.delete(); bram_q.delete(); glog.delete();
    m_out = 0; m_last_wr = 1'b0; m_free_cyc = 0;
    b_seen = 1'b0; r_seen = 1'b0; bv_cnt = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_awready", {31'd0, s_awready}, 32'd0);
    chk("rst_wready", {31'd0, s_wready}, 32'd0);
    chk("rst_arready", {31'd0, s_arready}, 32'd0);
    chk("rst_bvalid", {31'd0, s_bvalid}, 32'd0);
    chk("rst_rvalid", {31'd0, s_rvalid}, 32'd0);
    chk("rst_bram_en", {31'd0, bram_en}, 32'd0);
    chk("rst_bram_we", {28'd0, bram_we}, 32'd0);
    chk("rst_bram_addr", bram_addr, 32'd0);
    chk("rst_bram_din", bram_din, 32'd0);
    chk("rst_rdata", s_rdata, 32'd0);
    chk("rst_bresp", {30'd0, s_bresp}, 32'd0);
  endtask

  initial begin
    bit exp_order[4];
    int n;
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 16; i++) begin
      ref_mem[i] = $urandom;
      bmem[i]    = ref_mem[i];
    end
    ref_mem[1] = 32'h12345678;
    bmem[1]    = 32'h12345678;

    do_reset();

    // Read of an unaligned address returns the containing word.
    r_addr = 32'h10006; rpend = 1'b1;
    run_until_idle(30);

    // Full-word write, then read it back.
    w_addr = 32'h10004; w_data = 32'hDEADBEEF; w_strb = 4'hF; wpend = 1'b1;
    run_until_idle(30);
    r_addr = 32'h10004; rpend = 1'b1;
    run_until_idle(30);

    // Continuous write and read contention; bready held low 5 cycles per write.
    do_reset();
    hold5 = 1'b1; p_rready = 100;
    n = 0;
    while (glog.size() < 4 && n < 200) begin
      if (!wpend) new_write(4'hF);
      if (!rpend) new_read();
      step();
      n++;
    end
    if (glog.size() < 4) fail_now("order_timeout", "fewer than 4 grants under contention");
    else for (int i = 0; i < 4; i++) chk("grant_order", {31'd0, glog[i]}, {31'd0, exp_order[i]});
    run_until_idle(100);
    hold5 = 1'b0;

    // Partial strobe write, then read the word back.
    w_addr = 32'h10008; w_data = 32'hA5A5A5A5; w_strb = 4'h3; wpend = 1'b1;
    run_until_idle(30);
    r_addr = 32'h10008; rpend = 1'b1;
    run_until_idle(30);

    // Reset while the read is waiting on register file data.
    r_addr = 32'h10010; rpend = 1'b1;
    n = 0;
    while (rpend && n < 20) begin
      step();
      n++;
    end
    if (rpend) fail_now("rd_grant_timeout", "read never granted");
    step();
    step();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rvalid_after_rst", {31'd0, s_rvalid}, 32'd0);
    end

    // Randomized traffic with backpressure and partial strobes.
    p_vld = 80; p_bready = 60; p_rready = 60;
    for (int i = 0; i < 600; i++) begin
      if (!wpend && $urandom_range(99) < 25)
        new_write(($urandom_range(3) == 0) ? 4'($urandom) : 4'hF);
      if (!rpend && $urandom_range(99) < 25) new_read();
      step();
    end
    p_vld = 100; p_bready = 100; p_rready = 100;
    run_until_idle(200);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axil_bram_bridge.md
AXIL_BRAM_BRIDGE -- requirements
Module: axil_bram_bridge

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width of both ports.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width of both ports.
REQ-003 SHALL have parameter BYTE_NUM, default DATA_WIDTH/8, strobe and write-enable width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port s_awaddr  input  ADDR_WIDTH  AXI4-Lite write address.
REQ-007 SHALL have port s_awvalid  input  1  write address valid.
REQ-008 SHALL have port s_awready  output  1  write address ready.
REQ-009 SHALL have port s_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have port s_wstrb  input  BYTE_NUM  write byte strobes.
REQ-011 SHALL have port s_wvalid  input  1  write data valid.
REQ-012 SHALL have port s_wready  output  1  write data ready.
REQ-013 SHALL have port s_bresp  output  2  write response (00 OKAY, 10 SLVERR).
REQ-014 SHALL have port s_bvalid  output  1  write response valid.
REQ-015 SHALL have port s_bready  input  1  write response ready.
REQ-016 SHALL have port s_araddr  input  ADDR_WIDTH  read address.
REQ-017 SHALL have port s_arvalid  input  1  read address valid.
REQ-018 SHALL have port s_arready  output  1  read address ready.
REQ-019 SHALL have port s_rdata  output  DATA_WIDTH  read data.
REQ-020 SHALL have port s_rresp  output  2  read response, always 00.
REQ-021 SHALL have port s_rvalid  output  1  read data valid.
REQ-022 SHALL have port s_rready  input  1  read data ready.
REQ-023 SHALL have port bram_en  output  1  access strobe to the config register file.
REQ-024 SHALL have port bram_we  output  BYTE_NUM  byte write enables; all-zero for reads.
REQ-025 SHALL have port bram_addr  output  ADDR_WIDTH  byte address, low log2(BYTE_NUM) bits forced 0.
REQ-026 SHALL have port bram_din  output  DATA_WIDTH  write data to register file.
REQ-027 SHALL have port bram_dout  input  DATA_WIDTH  read data, valid one cycle after bram_en.

Function
REQ-028 SHALL implement FSM states IDLE, WR, WR_RESP, RD, RD_WAIT, RD_RESP.
REQ-029 SHALL, in IDLE only, accept a write when s_awvalid and s_wvalid are both high: s_awready=s_wready=1 that cycle (combinational), AW/W never accepted separately.
REQ-030 SHALL, in IDLE only, accept a read when s_arvalid is high and no write is granted: s_arready=1 that cycle.
REQ-031 SHALL arbitrate simultaneous eligible write and read round-robin: grant the type not granted last; after reset write has priority.
REQ-032 SHALL, write handshake in cycle T: WR in T+1 with bram_en=1, bram_we=s_wstrb, bram_addr, bram_din registered from T; s_bvalid=1 from T+2 held with s_bresp stable until s_bready, then IDLE.
REQ-033 SHALL, read handshake in cycle T: RD in T+1 with bram_en=1, bram_we=0; RD_WAIT in T+2 capturing bram_dout into s_rdata; s_rvalid=1 from T+3 held until s_rready, then IDLE.
REQ-034 SHALL keep bram_en=0 and bram_we=0 in every state except WR and RD; bram_addr/bram_din hold last value.
REQ-035 SHALL allow at most one outstanding transaction; all ready outputs 0 outside IDLE.
REQ-036 SHALL, with s_bready/s_rready already high when valid rises, return to IDLE next cycle (accept new request that cycle at earliest).

Reset
REQ-037 SHALL on rst, at any state, go to IDLE, clear all valid/ready/bram_en/bram_we, zero s_rdata, s_bresp, bram_addr, bram_din, reset arbiter to write-first; in-flight transaction abandoned without response.

Configuration
REQ-038 SHALL, with AXIL_BRAM_STRB_CHECK_EN defined, reject any write whose s_wstrb is not all-ones: no bram_en pulse (WR state still taken), s_bresp=10 SLVERR.
REQ-039 SHALL, without AXIL_BRAM_STRB_CHECK_EN, forward s_wstrb unchanged and always return s_bresp=00.

Structure
REQ-040 SHALL take state enum and AXI response constants (RESP_OKAY, RESP_SLVERR) from shared package sys_cfg_pkg; no sub-module, single-module FSM.

Verification
REQ-041 SHALL test write: awaddr=0x10004, wdata=0xDEADBEEF, wstrb=F -> bram_en=1, bram_we=F, bram_addr=0x10004 at T+1; bvalid at T+2, bresp=00.
REQ-042 SHALL test read: araddr=0x10006 with bram_dout=0x12345678 at T+2 -> bram_addr=0x10004, we=0 at T+1; rvalid at T+3, rdata=0x12345678.
REQ-043 SHALL test simultaneous AW+W and AR every cycle for 4 grants -> order W,R,W,R; bready held low 5 cycles -> bvalid/bresp stable, no new ready.
REQ-044 SHALL test wstrb=3: with AXIL_BRAM_STRB_CHECK_EN -> no bram_en, bresp=10; without -> bram_we=3, bresp=00; rst at RD_WAIT -> IDLE, rvalid never asserted.
